// File: rtl/regfile_sb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | regfile_sb: register file with write-first bypass, optional zero        |
// | register and per-register pending-write scoreboard.   Rev 1.0          |
// +------------------------------------------------------------------------+
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int CNT_W    = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ovf,
  output logic                     wr_unexp
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic                iss_ovf_q, iss_ovf_d;
  logic                wr_unexp_q, wr_unexp_d;
  logic                w_wr_ok;
  logic                w_iss_ok;

  // r0 is never written or issued, so its data and count stay at their reset value of 0.
  assign w_wr_ok  = wr_en  && !(ZERO_REG && (wr_addr  == '0));
  assign w_iss_ok = iss_en && !(ZERO_REG && (iss_addr == '0));

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      w_inc[r] = w_iss_ok && (iss_addr == ADDR_W'(r)) && (cnt_q[r] != CNT_MAX);
      w_dec[r] = w_wr_ok  && (wr_addr  == ADDR_W'(r)) && (cnt_q[r] != '0);
      if (w_inc[r] && !w_dec[r]) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (w_dec[r] && !w_inc[r]) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  assign iss_ovf_d  = w_iss_ok && (cnt_q[iss_addr] == CNT_MAX);
  assign wr_unexp_d = w_wr_ok && (cnt_q[wr_addr] == '0) && !(iss_en && (iss_addr == wr_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      iss_ovf_q  <= 1'b0;
      wr_unexp_q <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        mem_q[wr_addr] <= wr_data;
      end
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      iss_ovf_q  <= iss_ovf_d;
      wr_unexp_q <= wr_unexp_d;
    end
  end

  assign iss_ovf  = iss_ovf_q;
  assign wr_unexp = wr_unexp_q;

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
      assign rd_data[k*DATA_W +: DATA_W] =
        (ZERO_REG && (w_addr == '0))       ? '0 :
        (wr_en && (wr_addr == w_addr))     ? wr_data :
                                             mem_q[w_addr];
      // Busy reflects the registered count only; same-cycle issue/write is not bypassed.
      assign rd_busy[k] = (cnt_q[w_addr] != '0);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_regfile_sb: two configurations of regfile_sb driven in lockstep      |
// | and compared against a behavioural model.              Rev 1.0         |
// +------------------------------------------------------------------------+
module tb_regfile_sb;

  localparam int CMAX = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   ra [3];
  logic         wr_en = 1'b0;
  logic         iss_en = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [4:0]   iss_addr = '0;
  logic [63:0]  wr_data = '0;

  logic [63:0]  rda;
  logic [1:0]   busy_a;
  logic         ovf_a, unx_a;
  logic [191:0] rdb;
  logic [2:0]   busy_b;
  logic         ovf_b, unx_b;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_mem [2][32];
  int          m_cnt [2][32];
  bit          e_ovf [2];
  bit          e_unx [2];

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .CNT_W(2), .ZERO_REG(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .rd_addr({ra[1], ra[0]}), .rd_data(rda), .rd_busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[31:0]),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_ovf(ovf_a), .wr_unexp(unx_a)
  );

  regfile_sb #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(3), .CNT_W(2), .ZERO_REG(1'b1)) dut_b (
    .clk(clk), .rst(rst),
    .rd_addr({ra[2][3:0], ra[1][3:0], ra[0][3:0]}), .rd_data(rdb), .rd_busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr[3:0]), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr[3:0]),
    .iss_ovf(ovf_b), .wr_unexp(unx_b)
  );

  function automatic int msk(int d);
    return (d == 0) ? 31 : 15;
  endfunction

  function automatic logic [63:0] dmsk(int d);
    return (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] act_rd(int d, int k);
    return (d == 0) ? {32'b0, rda[k*32 +: 32]} : rdb[k*64 +: 64];
  endfunction

  function automatic logic act_busy(int d, int k);
    return (d == 0) ? busy_a[k] : busy_b[k];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: registers hold values, counters track outstanding writes in 0..CMAX.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 32; r++) begin
          m_mem[d][r] <= '0;
          m_cnt[d][r] <= 0;
        end
        e_ovf[d] <= 1'b0;
        e_unx[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        automatic int wa  = int'(wr_addr) & msk(d);
        automatic int ia  = int'(iss_addr) & msk(d);
        automatic bit wv  = wr_en && (wa != 0);
        automatic bit iv  = iss_en && (ia != 0);
        automatic bit inc = iv && (m_cnt[d][ia] < CMAX);
        automatic bit dec = wv && (m_cnt[d][wa] > 0);
        e_ovf[d] <= iv && (m_cnt[d][ia] == CMAX);
        e_unx[d] <= wv && (m_cnt[d][wa] == 0) && !(iss_en && (ia == wa));
        if (wv) m_mem[d][wa] <= wr_data & dmsk(d);
        if (!(inc && dec && (ia == wa))) begin
          if (inc) m_cnt[d][ia] <= m_cnt[d][ia] + 1;
          if (dec) m_cnt[d][wa] <= m_cnt[d][wa] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < ((d == 0) ? 2 : 3); k++) begin
        automatic int a = int'(ra[k]) & msk(d);
        automatic logic [63:0] ex;
        if (a == 0) ex = '0;
        else if (wr_en && ((int'(wr_addr) & msk(d)) == a)) ex = wr_data & dmsk(d);
        else ex = m_mem[d][a];
        chk($sformatf("rd_dut%0d_p%0d", d, k), act_rd(d, k), ex);
        chk($sformatf("busy_dut%0d_p%0d", d, k), 64'(act_busy(d, k)), 64'(m_cnt[d][a] != 0));
      end
    end
    chk("ovf_dut0", 64'(ovf_a), 64'(e_ovf[0]));
    chk("ovf_dut1", 64'(ovf_b), 64'(e_ovf[1]));
    chk("unx_dut0", 64'(unx_a), 64'(e_unx[0]));
    chk("unx_dut1", 64'(unx_b), 64'(e_unx[1]));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    iss_en = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] dt);
    wr_en = 1'b1; wr_addr = a; wr_data = dt; iss_en = 1'b0;
    tick();
    idle();
  endtask

  task automatic iss(input logic [4:0] a);
    iss_en = 1'b1; iss_addr = a; wr_en = 1'b0;
    tick();
    idle();
  endtask

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
  endfunction

  initial begin
    ra[0] = '0; ra[1] = '0; ra[2] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ra[0] = 5'd5; ra[1] = 5'd5; ra[2] = 5'd5;
    #3 chk("reset_rd", rda, 64'h0);
    chk("reset_busy", 64'(busy_a), 64'h0);
    tick();

    wr(5'd5, 64'hDEAD_BEEF);
    #3 chk("wr5_p0", 64'(rda[31:0]), 64'hDEAD_BEEF);
    chk("wr5_p1", 64'(rda[63:32]), 64'hDEAD_BEEF);
    chk("wr5_b_p2", rdb[191:128], 64'hDEAD_BEEF);
    tick();

    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h1234; ra[0] = 5'd7;
    #3 chk("bypass_r7", 64'(rda[31:0]), 64'h1234);
    tick();
    idle();

    wr_en = 1'b1; wr_addr = 5'd0; wr_data = '1; ra[0] = 5'd0;
    #3 chk("r0_no_bypass", 64'(rda[31:0]), 64'h0);
    tick();
    idle();
    #3 chk("r0_read", rdb[63:0], 64'h0);
    chk("r0_unexp", 64'(unx_a), 64'h0);
    tick();

    iss(5'd3);
    ra[0] = 5'd3;
    #3 chk("busy_r3", 64'(busy_a[0]), 64'h1);
    tick();
    wr(5'd3, 64'h33);
    #3 chk("retire_r3", 64'(busy_a[0]), 64'h0);
    chk("retire_r3_unexp", 64'(unx_a), 64'h0);
    tick();

    repeat (3) iss(5'd9);
    ra[0] = 5'd9;
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    idle();
    #3 chk("ovf_a_pulse", 64'(ovf_a), 64'h1);
    chk("ovf_b_pulse", 64'(ovf_b), 64'h1);
    tick();
    #3 chk("ovf_a_single", 64'(ovf_a), 64'h0);
    tick();
    wr(5'd9, 64'h1);
    wr(5'd9, 64'h2);
    #3 chk("waw_still_busy", 64'(busy_a[0]), 64'h1);
    tick();
    wr(5'd9, 64'h3);
    #3 chk("waw_done", 64'(busy_a[0]), 64'h0);
    chk("waw_data", 64'(rda[31:0]), 64'h3);
    tick();

    iss(5'd4);
    ra[0] = 5'd4;
    iss_en = 1'b1; iss_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h44;
    tick();
    idle();
    #3 chk("simul_cnt1_busy", 64'(busy_b[0]), 64'h1);
    tick();
    wr(5'd4, 64'h45);
    iss_en = 1'b1; iss_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h46;
    tick();
    idle();
    #3 chk("simul_cnt0_busy", 64'(busy_a[0]), 64'h1);
    chk("simul_cnt0_unexp", 64'(unx_a), 64'h0);
    tick();
    wr(5'd4, 64'h47);

    wr(5'd12, 64'h00C0_FFEE);
    ra[0] = 5'd12;
    #3 chk("unexp_data", 64'(rda[31:0]), 64'h00C0_FFEE);
    chk("unexp_a", 64'(unx_a), 64'h1);
    chk("unexp_b", 64'(unx_b), 64'h1);
    tick();
    #3 chk("unexp_single", 64'(unx_a), 64'h0);
    tick();

    ra[0] = 5'd5; ra[1] = 5'd12;
    #3 rst = 1'b1;
    #1 chk("midrst_a", rda, 64'h0);
    chk("midrst_b", rdb[127:0] == '0 ? 64'h0 : 64'h1, 64'h0);
    tick();
    tick();
    rst = 1'b0;

    repeat (2000) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = rnd_addr();
      wr_data  = {32'($urandom), 32'($urandom)};
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = rnd_addr();
      for (int k = 0; k < 3; k++) ra[k] = rnd_addr();
      tick();
    end
    idle();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
